uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/uart_frame_parser_if.sv | 30 +++
 rtl/uart_frame_parser_frame_buf.sv | 25 ++
 rtl/uart_frame_parser.sv | 160 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and default parameters for the UART framing stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } state_e;

    localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
    localparam int         MAX_LEN_DEFAULT = 16;
    localparam int         TIMEOUT_DEFAULT = 50000;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / payload-out bundle for the UART frame parser, plus its error pulses.
// Latency: n/a (wires only).
// Backpressure: out_ready throttles the payload stream; rx side has none.
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frame_len;
    logic       chk_err;
    logic       len_err;
    logic       timeout_err;
    logic       overrun;

    // Byte source and payload consumer side.
    modport master (
        output rx_data, rx_valid, out_ready,
        input  out_data, out_valid, out_last, frame_len,
        input  chk_err, len_err, timeout_err, overrun
    );

    // Parser side.
    modport slave (
        input  rx_data, rx_valid, out_ready,
        output out_data, out_valid, out_last, frame_len,
        output chk_err, len_err, timeout_err, overrun
    );
endinterface

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload register file: DEPTH x 8, synchronous write, combinational read, no reset.
// Latency: write visible on the read port the cycle after we; read is same-cycle.
// Backpressure: none; the parser guarantees writes and reads never collide.
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [DEPTH];

    // Store one payload byte per write strobe; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_frame_parser.sv
// Hunts SOF, collects LEN payload bytes, verifies the additive checksum, replays good payloads.
// Latency: first payload byte is offered the cycle after the CHK byte; errors pulse one cycle after cause.
// Backpressure: out_ready stalls the drain with outputs held; rx bytes arriving during drain are dropped (overrun).
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT,
    parameter int         TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    uart_frame_parser_if.slave  bus
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    len_q, len_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          chk_err_q, chk_err_d;
    logic          len_err_q, len_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic          overrun_q, overrun_d;
    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic          in_drain;
    logic          is_last;
    logic          timed;

    frame_buf #(.DEPTH(MAX_LEN), .IW(IW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_idx_q),
        .wdata (bus.rx_data),
        .raddr (rd_idx_q),
        .rdata (buf_rdata)
    );

    assign in_drain = (state_q == DRAIN);
    assign is_last  = (8'(rd_idx_q) == len_q - 8'd1);
    assign timed    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);

    // Buffer contents are masked outside DRAIN so stale payload never leaks out.
    assign bus.out_valid   = in_drain;
    assign bus.out_data    = in_drain ? buf_rdata : 8'h00;
    assign bus.out_last    = in_drain && is_last;
    assign bus.frame_len   = len_q;
    assign bus.chk_err     = chk_err_q;
    assign bus.len_err     = len_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun     = overrun_q;

    // Next-state logic: framing FSM, checksum accumulation, indices and inter-byte timeout.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        len_d         = len_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        tmo_d         = '0;
        chk_err_d     = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = 1'b0;
        buf_we        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == SOF) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > MAX_LEN) begin
                        len_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        len_d    = bus.rx_data;
                        acc_d    = bus.rx_data;
                        wr_idx_d = '0;
                        state_d  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    buf_we   = 1'b1;
                    acc_d    = acc_q + bus.rx_data;
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (8'(wr_idx_q) == len_q - 8'd1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == acc_q) begin
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            DRAIN: begin
                overrun_d = bus.rx_valid;
                if (bus.out_ready) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte landing in the same cycle the count hits TIMEOUT wins over the timeout.
        if (timed && !bus.rx_valid) begin
            if (tmo_q == TW'(TIMEOUT)) begin
                timeout_err_d = 1'b1;
                state_d       = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // State and datapath registers; reset discards any frame in progress silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            len_q         <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            tmo_q         <= '0;
            chk_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            len_q         <= len_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            tmo_q         <= tmo_d;
            chk_err_q     <= chk_err_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized checks of uart_frame_parser against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: out_ready driven directly or randomized per cycle.
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_frame_parser_if bus();

    uart_frame_parser #(.SOF(8'hA5), .MAX_LEN(16), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 1'b0;

    // Monitor: record every accepted payload byte and count error-pulse cycles.
    logic [7:0] got_dat[$];
    bit         got_last[$];
    logic [7:0] got_len[$];
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got_dat.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
            got_len.push_back(bus.frame_len);
        end
        if (bus.chk_err === 1'b1)     n_chk++;
        if (bus.len_err === 1'b1)     n_len++;
        if (bus.timeout_err === 1'b1) n_tmo++;
        if (bus.overrun === 1'b1)     n_ovr++;
    end

    int b_chk, b_len, b_tmo, b_ovr;

    task automatic mark();
        b_chk = n_chk; b_len = n_len; b_tmo = n_tmo; b_ovr = n_ovr;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of rx input; the DUT samples it at the following posedge.
    task automatic step(input bit v, input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_valid = v;
        bus.rx_data  = b;
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] q[$]);
        foreach (q[i]) begin
            step(1'b1, q[i]);
            if (rnd_rdy) repeat ($urandom_range(0, 2)) step(1'b0, 8'h00);
        end
    endtask

    logic [7:0] fr[$];
    logic [7:0] pl[$];
    logic [7:0] exp_dat[$];
    bit         exp_last[$];
    logic [7:0] exp_len[$];
    int exp_chk, exp_lerr, base, wait_cnt, len, nmin;
    logic [7:0] sum, cb, gb;
    bit bad;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state.
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_frame_len", bus.frame_len, 0);
        check("rst_errs", {bus.chk_err, bus.len_err, bus.timeout_err, bus.overrun}, 0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        step(1'b0, 8'h00);

        // Good frame, full throughput.
        mark();
        fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send(fr);
        step(1'b0, 8'h00);
        check("good_v0", bus.out_valid, 1);
        check("good_d0", bus.out_data, 8'h11);
        check("good_l0", bus.out_last, 0);
        check("good_len", bus.frame_len, 3);
        step(1'b0, 8'h00);
        check("good_d1", bus.out_data, 8'h22);
        check("good_l1", bus.out_last, 0);
        step(1'b0, 8'h00);
        check("good_d2", bus.out_data, 8'h33);
        check("good_l2", bus.out_last, 1);
        step(1'b0, 8'h00);
        check("good_done", bus.out_valid, 0);
        check("good_noerr", (n_chk - b_chk) + (n_len - b_len) + (n_tmo - b_tmo) + (n_ovr - b_ovr), 0);

        // Bad checksum, then a good one-byte frame.
        mark();
        fr = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
        send(fr);
        step(1'b0, 8'h00);
        check("badchk_pulse", bus.chk_err, 1);
        check("badchk_novalid", bus.out_valid, 0);
        step(1'b0, 8'h00);
        check("badchk_pulse_end", bus.chk_err, 0);
        fr = {8'hA5, 8'h01, 8'h07, 8'h08};
        send(fr);
        step(1'b0, 8'h00);
        check("one_d", bus.out_data, 8'h07);
        check("one_last", bus.out_last, 1);
        check("one_len", bus.frame_len, 1);
        step(1'b0, 8'h00);
        check("one_done", bus.out_valid, 0);
        check("badchk_count", n_chk - b_chk, 1);

        // Length errors and the largest legal length.
        mark();
        fr = {8'hA5, 8'h00};
        send(fr);
        step(1'b0, 8'h00);
        check("len0_err", bus.len_err, 1);
        check("len0_state", 32'(dut.state_q), 32'(IDLE));
        fr = {8'hA5, 8'h11};
        send(fr);
        step(1'b0, 8'h00);
        check("len17_err", bus.len_err, 1);
        check("len17_state", 32'(dut.state_q), 32'(IDLE));
        fr = {8'hA5, 8'h10};
        sum = 8'h10;
        for (int i = 0; i < 16; i++) begin
            fr.push_back(8'(i * 3 + 1));
            sum = sum + 8'(i * 3 + 1);
        end
        fr.push_back(sum);
        send(fr);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00);
            check("len16_d", bus.out_data, 8'(i * 3 + 1));
            check("len16_last", bus.out_last, (i == 15) ? 1 : 0);
        end
        step(1'b0, 8'h00);
        check("len16_done", bus.out_valid, 0);
        check("len_err_count", n_len - b_len, 2);

        // Inter-byte timeout, then a byte landing exactly on the limit.
        mark();
        fr = {8'hA5, 8'h02, 8'h01};
        send(fr);
        repeat (TMO + 1) step(1'b0, 8'h00);
        check("tmo_early", bus.timeout_err, 0);
        step(1'b0, 8'h00);
        check("tmo_pulse", bus.timeout_err, 1);
        check("tmo_state", 32'(dut.state_q), 32'(IDLE));
        step(1'b0, 8'h00);
        check("tmo_pulse_end", bus.timeout_err, 0);
        check("tmo_count", n_tmo - b_tmo, 1);
        mark();
        fr = {8'hA5, 8'h02, 8'h01};
        send(fr);
        repeat (TMO) step(1'b0, 8'h00);
        fr = {8'h02, 8'h05};
        send(fr);
        step(1'b0, 8'h00);
        check("edge_d0", bus.out_data, 8'h01);
        check("edge_v0", bus.out_valid, 1);
        step(1'b0, 8'h00);
        check("edge_d1", bus.out_data, 8'h02);
        check("edge_l1", bus.out_last, 1);
        check("edge_notmo", n_tmo - b_tmo, 0);

        // Backpressure with overrun injection.
        step(1'b0, 8'h00);
        mark();
        bus.out_ready = 1'b0;
        fr = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
        send(fr);
        step(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step((i == 2 || i == 5 || i == 6), 8'h5A);
            check("bp_valid", bus.out_valid, 1);
            check("bp_data", bus.out_data, 8'hAA);
            check("bp_last", bus.out_last, 0);
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check("bp_hold_len", bus.frame_len, 2);
        check("ovr_count", n_ovr - b_ovr, 3);
        bus.out_ready = 1'b1;
        step(1'b0, 8'h00);
        check("bp_d1", bus.out_data, 8'hBB);
        check("bp_l1", bus.out_last, 1);
        step(1'b0, 8'h00);
        check("bp_done", bus.out_valid, 0);

        // Reset mid-payload, then a fresh frame.
        mark();
        fr = {8'hA5, 8'h04, 8'h01, 8'h02};
        send(fr);
        step(1'b0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_data", bus.out_data, 0);
        check("mrst_len", bus.frame_len, 0);
        check("mrst_state", 32'(dut.state_q), 32'(IDLE));
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b1;
        base = got_dat.size();
        fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send(fr);
        repeat (5) step(1'b0, 8'h00);
        check("mrst_count", got_dat.size() - base, 3);
        if (got_dat.size() - base == 3) begin
            check("mrst_d2", got_dat[base + 2], 8'h33);
            check("mrst_l2", got_last[base + 2], 1);
        end
        check("mrst_noerr", (n_chk - b_chk) + (n_len - b_len) + (n_tmo - b_tmo) + (n_ovr - b_ovr), 0);

        // Randomized frames with random gaps and random backpressure.
        mark();
        base = got_dat.size();
        exp_chk = 0;
        exp_lerr = 0;
        rnd_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                gb = 8'($urandom_range(0, 255));
                if (gb == 8'hA5) gb = 8'h00;
                step(1'b1, gb);
            end
            len = $urandom_range(0, 18);
            fr = {8'hA5, 8'(len)};
            if (len == 0 || len > 16) begin
                exp_lerr++;
            end else begin
                pl = {};
                sum = 8'(len);
                for (int i = 0; i < len; i++) begin
                    pl.push_back(8'($urandom_range(0, 255)));
                    sum = sum + pl[i];
                end
                bad = ($urandom_range(0, 3) == 0);
                cb = bad ? (sum ^ 8'($urandom_range(1, 255))) : sum;
                fr = {fr, pl, cb};
                if (bad) begin
                    exp_chk++;
                end else begin
                    foreach (pl[i]) begin
                        exp_dat.push_back(pl[i]);
                        exp_last.push_back(i == len - 1);
                        exp_len.push_back(8'(len));
                    end
                end
            end
            send(fr);
            step(1'b0, 8'h00);
            wait_cnt = 0;
            while (bus.out_valid === 1'b1 && wait_cnt < 300) begin
                step(1'b0, 8'h00);
                wait_cnt++;
            end
            if (wait_cnt >= 300) check("rnd_drain_wait", wait_cnt, 0);
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step(1'b0, 8'h00);
        check("rnd_count", got_dat.size() - base, exp_dat.size());
        nmin = (got_dat.size() - base < exp_dat.size()) ? got_dat.size() - base : exp_dat.size();
        for (int i = 0; i < nmin; i++) begin
            check("rnd_data", got_dat[base + i], exp_dat[i]);
            check("rnd_last", got_last[base + i], exp_last[i]);
            check("rnd_len", got_len[base + i], exp_len[i]);
        end
        check("rnd_chk_err", n_chk - b_chk, exp_chk);
        check("rnd_len_err", n_len - b_len, exp_lerr);
        check("rnd_tmo_err", n_tmo - b_tmo, 0);
        check("rnd_overrun", n_ovr - b_ovr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
